// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared bus command and owner encodings for the memory-side arbiter
package sys_defs;

  localparam int XLEN = 32;
  localparam int PREF = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'h0,
    OWN_D    = 2'h1,
    OWN_I    = 2'h2,
    OWN_P    = 2'h3
  } owner_t;

endpackage

// File: rtl/mem_tag_table.sv
// rtl/mem_tag_table.sv - 15-entry owner store keyed by memory tags 1..15
import sys_defs::*;

module mem_tag_table (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_tag,
  input  owner_t     wr_owner,
  input  logic       clr_en,
  input  logic [3:0] rd_tag,
  output owner_t     rd_owner
);

  owner_t owner_q [1:15];

  // Write follows clear so a same-tag completion/acceptance leaves the new owner.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 1; i <= 15; i++) owner_q[i] <= OWN_NONE;
    end else begin
      if (clr_en && rd_tag != 4'd0) owner_q[rd_tag] <= OWN_NONE;
      if (wr_en && wr_tag != 4'd0) owner_q[wr_tag] <= wr_owner;
    end
  end

  assign rd_owner = (rd_tag == 4'd0) ? OWN_NONE : owner_q[rd_tag];

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - dcache/icache/prefetch arbiter onto one memory port with tag routing
import sys_defs::*;

module mem_bus_arbiter #(
  parameter int AGE_LIMIT = 4,
  parameter int PREF_MAX  = PREF
) (
  input  logic            clock,
  input  logic            reset,
  input  bus_command_t    d_command,
  input  bus_command_t    i_command,
  input  bus_command_t    p_command,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] p_addr,
  input  logic [63:0]     d_data,
  output bus_command_t    proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [3:0]      mem2proc_tag,
  input  logic [63:0]     mem2proc_data,
  output logic [3:0]      d_response,
  output logic [3:0]      i_response,
  output logic [3:0]      p_response,
  output logic [3:0]      d_tag,
  output logic [3:0]      i_tag,
  output logic [3:0]      p_tag,
  output logic [63:0]     mem_data,
  output logic            p_give_way,
  output logic            spurious_tag
);

  localparam int PREF_W = $clog2(PREF_MAX) + 1;

  owner_t            grant;
  owner_t            cpl_owner;
  logic [2:0]        age_cnt;
  logic [PREF_W-1:0] pref_out;
  logic              spur_q;
  logic              d_req, i_req, p_req, p_elig, age_max;
  logic              accept, cpl_valid, pref_inc, pref_dec;

  assign d_req     = (d_command != BUS_NONE);
  assign i_req     = (i_command != BUS_NONE);
  assign p_req     = (p_command != BUS_NONE);
  assign age_max   = (age_cnt == 3'(AGE_LIMIT));
  assign p_elig    = p_req && (pref_out != PREF_W'(PREF_MAX));
  assign accept    = (grant != OWN_NONE) && (mem2proc_response != 4'd0);
  assign cpl_valid = reset && (mem2proc_tag != 4'd0);
  assign pref_inc  = accept && (grant == OWN_P);
  assign pref_dec  = cpl_valid && (cpl_owner == OWN_P);

  // A starved icache jumps ahead of dcache; nothing is granted while in reset.
  always_comb begin
    grant = OWN_NONE;
    if (reset) begin
      if (i_req && age_max) grant = OWN_I;
      else if (d_req)       grant = OWN_D;
      else if (i_req)       grant = OWN_I;
      else if (p_elig)      grant = OWN_P;
    end
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    case (grant)
      OWN_D: begin
        proc2mem_command = d_command;
        proc2mem_addr    = d_addr;
        proc2mem_data    = d_data;
      end
      OWN_I: begin
        proc2mem_command = i_command;
        proc2mem_addr    = i_addr;
      end
      OWN_P: begin
        proc2mem_command = p_command;
        proc2mem_addr    = p_addr;
      end
      default: ;
    endcase
  end

  assign d_response   = (grant == OWN_D) ? mem2proc_response : 4'd0;
  assign i_response   = (grant == OWN_I) ? mem2proc_response : 4'd0;
  assign p_response   = (grant == OWN_P) ? mem2proc_response : 4'd0;
  assign d_tag        = (cpl_valid && cpl_owner == OWN_D) ? mem2proc_tag : 4'd0;
  assign i_tag        = (cpl_valid && cpl_owner == OWN_I) ? mem2proc_tag : 4'd0;
  assign p_tag        = (cpl_valid && cpl_owner == OWN_P) ? mem2proc_tag : 4'd0;
  assign mem_data     = mem2proc_data;
  assign p_give_way   = reset && p_req && (grant != OWN_P);
  assign spurious_tag = reset && spur_q;

  mem_tag_table u_tag_table (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (accept),
    .wr_tag   (mem2proc_response),
    .wr_owner (grant),
    .clr_en   (cpl_valid),
    .rd_tag   (mem2proc_tag),
    .rd_owner (cpl_owner)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      age_cnt  <= 3'd0;
      pref_out <= '0;
      spur_q   <= 1'b0;
    end else begin
      if (grant == OWN_I)        age_cnt <= 3'd0;
      else if (i_req && !age_max) age_cnt <= age_cnt + 3'd1;
      // Simultaneous accept and completion of prefetch cancel out.
      if (pref_inc && !pref_dec && pref_out != PREF_W'(PREF_MAX))
        pref_out <= pref_out + PREF_W'(1);
      else if (pref_dec && !pref_inc && pref_out != '0)
        pref_out <= pref_out - PREF_W'(1);
      if (cpl_valid && cpl_owner == OWN_NONE) spur_q <= 1'b1;
    end
  end

endmodule
